// File: rtl/keypad_scanner_if.sv
// Key handoff bundle between the keypad scanner and the register/ALU datapath.
// The scanner drives the master side; the consumer drives key_ready.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: column scan, row debounce, hex mapping and a
// one-entry valid/ready holding register with a sticky overrun flag.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         row,
  output logic [3:0]         col,
  keypad_scanner_if.master   kif
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_row_s1;
  logic [3:0]  r_row_s2;
  logic [1:0]  r_col_idx;
  logic [15:0] r_dwell;
  logic [19:0] r_deb;
  logic [1:0]  r_cand;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_overrun;

  state_t      w_state_nxt;
  logic [1:0]  w_col_nxt;
  logic [15:0] w_dwell_nxt;
  logic [19:0] w_deb_nxt;
  logic [1:0]  w_cand_nxt;
  logic        w_accept;
  logic        w_any_low;
  logic [1:0]  w_lowest;
  logic        w_match;
  logic [3:0]  w_key;

  assign col           = ~(4'b0001 << r_col_idx);
  assign kif.key_code  = r_key_code;
  assign kif.key_valid = r_key_valid;
  assign kif.overrun   = r_overrun;

  // Lowest low row wins; a debounce match therefore means the candidate row
  // is low and every lower-index row is high.
  always_comb begin
    w_lowest = 2'd0;
    if (!r_row_s2[3]) w_lowest = 2'd3;
    if (!r_row_s2[2]) w_lowest = 2'd2;
    if (!r_row_s2[1]) w_lowest = 2'd1;
    if (!r_row_s2[0]) w_lowest = 2'd0;
  end

  assign w_any_low = (r_row_s2 != 4'hF);
  assign w_match   = w_any_low && (w_lowest == r_cand);

  always_comb begin
    w_key = 4'h0;
    case ({r_cand, r_col_idx})
      4'b00_00: w_key = 4'h1;
      4'b00_01: w_key = 4'h2;
      4'b00_10: w_key = 4'h3;
      4'b00_11: w_key = 4'hA;
      4'b01_00: w_key = 4'h4;
      4'b01_01: w_key = 4'h5;
      4'b01_10: w_key = 4'h6;
      4'b01_11: w_key = 4'hB;
      4'b10_00: w_key = 4'h7;
      4'b10_01: w_key = 4'h8;
      4'b10_10: w_key = 4'h9;
      4'b10_11: w_key = 4'hC;
      4'b11_00: w_key = 4'h0;
      4'b11_01: w_key = 4'hF;
      4'b11_10: w_key = 4'hE;
      4'b11_11: w_key = 4'hD;
      default:  w_key = 4'h0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_dwell_nxt = r_dwell;
    w_deb_nxt   = r_deb;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_dwell == SCAN_DIV - 16'd1) begin
          w_dwell_nxt = '0;
          if (w_any_low) begin
            w_cand_nxt  = w_lowest;
            w_deb_nxt   = '0;
            w_state_nxt = DEBOUNCE;
          end else begin
            w_col_nxt = r_col_idx + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (!w_match) begin
          w_state_nxt = SCAN;
          w_col_nxt   = r_col_idx + 2'd1;
          w_deb_nxt   = '0;
          w_dwell_nxt = '0;
        end else if (r_deb == DEBOUNCE_CNT - 20'd1) begin
          w_accept    = 1'b1;
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb + 20'd1;
        end
      end
      HELD: begin
        if (w_any_low) begin
          w_deb_nxt = '0;
        end else if (r_deb == DEBOUNCE_CNT - 20'd1) begin
          w_state_nxt = SCAN;
          w_col_nxt   = r_col_idx + 2'd1;
          w_deb_nxt   = '0;
          w_dwell_nxt = '0;
        end else begin
          w_deb_nxt = r_deb + 20'd1;
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_deb_nxt   = '0;
        w_dwell_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= SCAN;
      r_row_s1  <= '1;
      r_row_s2  <= '1;
      r_col_idx <= '0;
      r_dwell   <= '0;
      r_deb     <= '0;
      r_cand    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_s1  <= row;
      r_row_s2  <= r_row_s1;
      r_col_idx <= w_col_nxt;
      r_dwell   <= w_dwell_nxt;
      r_deb     <= w_deb_nxt;
      r_cand    <= w_cand_nxt;
    end
  end

  // A transfer on the accept cycle frees the slot, so the new key still loads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_accept) begin
      if (!r_key_valid || kif.key_ready) begin
        r_key_code  <= w_key;
        r_key_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_key_valid && kif.key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from the
// pressed-key map and the active column; expectations come from the key table.
module tb_keypad_scanner;
  localparam int          SD      = 4;
  localparam int          DC      = 8;
  localparam int unsigned VBUDGET = 4*SD + DC + 3 + 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] press [4];

  int checks = 0;
  int errors = 0;

  logic       exp_valid;
  logic [3:0] exp_code;
  logic       exp_ovr;

  logic [3:0] keymap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(20'd8)) dut (
    .clock (clock),
    .reset (reset),
    .row   (row),
    .col   (col),
    .kif   (kif)
  );

  always #5 clock = ~clock;

  // Pressed switches short their row to whichever column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col[c] == 1'b0) row = row & ~press[c];
  end

  function automatic logic [3:0] model_code(input logic [3:0] mask, input int c);
    logic [3:0] code;
    code = 4'h0;
    for (int r = 3; r >= 0; r--)
      if (mask[r]) code = keymap[r][c];
    return code;
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] p;
    p = 4'b0001 << c;
    return ~p;
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction

  task automatic release_all();
    for (int c = 0; c < 4; c++) press[c] = 4'h0;
  endtask

  task automatic wait_valid(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clock);
      if (kif.key_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_col_not(input logic [3:0] p, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clock);
      if (col !== p) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_col_is(input logic [3:0] p, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clock);
      if (col === p) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_ready();
    @(negedge clock);
    kif.key_ready = 1'b1;
    @(negedge clock);
    kif.key_ready = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    release_all();
    kif.key_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", col); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", kif.key_valid); end
    checks++; if (kif.key_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", kif.key_code); end
    checks++; if (kif.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", kif.overrun); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_valid = 1'b0; exp_code = 4'h0; exp_ovr = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int run;
    bit first;
    prev = col; run = 1; first = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++; if ($countones(~col) != 1) begin errors++; $display("FAIL scan_onehot got=%b exp=one low bit", col); end
      if (col !== prev) begin
        checks++; if (col !== rot(prev)) begin errors++; $display("FAIL scan_order got=%b exp=%b", col, rot(prev)); end
        if (!first) begin
          checks++; if (run != SD) begin errors++; $display("FAIL scan_dwell got=%0d exp=%0d", run, SD); end
        end
        first = 1'b0; run = 1; prev = col;
      end else begin
        run++;
      end
      checks++; if (kif.key_valid !== 1'b0 || kif.overrun !== 1'b0) begin
        errors++; $display("FAIL scan_idle got=valid %b ovr %b exp=0 0", kif.key_valid, kif.overrun);
      end
    end
  endtask

  task automatic test_press_hold();
    bit ok;
    int bad;
    press[2] = 4'b0010;
    wait_valid(VBUDGET, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_valid_timeout got=0 exp=1"); end
    checks++; if (kif.key_code !== 4'h6) begin errors++; $display("FAIL hold_code got=%h exp=6", kif.key_code); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (col !== 4'b1011 || kif.key_valid !== 1'b1 || kif.overrun !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_col_stable got=%0d bad cycles exp=0", bad); end
    press[2] = 4'h0;
    wait_col_not(4'b1011, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_release_timeout got=0 exp=1"); end
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h6) begin
      errors++; $display("FAIL hold_after_release got=%b/%h exp=1/6", kif.key_valid, kif.key_code);
    end
    pulse_ready();
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL hold_transfer got=%b exp=0", kif.key_valid); end
  endtask

  task automatic test_bounce();
    bit ok;
    int bad;
    wait_col_not(4'b1110, 20, ok);
    wait_col_is(4'b1110, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_sync_timeout got=0 exp=1"); end
    press[0] = 4'b0001;
    repeat (3) @(negedge clock);
    press[0] = 4'h0;
    wait_col_not(4'b1110, 20, ok);
    checks++; if (!ok || col !== 4'b1101) begin errors++; $display("FAIL bounce_next_col got=%b exp=1101", col); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (kif.key_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_no_key got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_two_rows();
    bit ok;
    press[3] = 4'b1001;
    wait_valid(VBUDGET, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tworow_timeout got=0 exp=1"); end
    checks++; if (kif.key_code !== model_code(4'b1001, 3)) begin
      errors++; $display("FAIL tworow_code got=%h exp=%h", kif.key_code, model_code(4'b1001, 3));
    end
    press[3] = 4'h0;
    wait_col_not(4'b0111, 30, ok);
    pulse_ready();
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL tworow_transfer got=%b exp=0", kif.key_valid); end
  endtask

  task automatic test_random_keys();
    bit ok;
    int c;
    logic [3:0] mask;
    for (int n = 0; n < 10; n++) begin
      c = int'($urandom_range(0, 3));
      mask = 4'($urandom_range(1, 15));
      wait_col_not(col_pat(c), 20, ok);
      press[c] = mask;
      exp_code = model_code(mask, c);
      exp_valid = 1'b1;
      wait_valid(VBUDGET, ok);
      checks++; if (!ok || kif.key_code !== exp_code) begin
        errors++; $display("FAIL rand_code key c%0d m%b got=%b/%h exp=1/%h", c, mask, kif.key_valid, kif.key_code, exp_code);
      end
      repeat ($urandom_range(0, 15)) @(negedge clock);
      press[c] = 4'h0;
      wait_col_not(col_pat(c), 30, ok);
      checks++; if (!ok || kif.key_valid !== exp_valid || kif.key_code !== exp_code) begin
        errors++; $display("FAIL rand_released got=%b/%h exp=%b/%h", kif.key_valid, kif.key_code, exp_valid, exp_code);
      end
      repeat ($urandom_range(0, 5)) @(negedge clock);
      pulse_ready();
      checks++; if (kif.key_valid !== exp_valid || kif.overrun !== exp_ovr) begin
        errors++; $display("FAIL rand_transfer got=%b/%b exp=%b/%b", kif.key_valid, kif.overrun, exp_valid, exp_ovr);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    press[1] = 4'b0010;
    wait_valid(VBUDGET, ok);
    checks++; if (!ok || kif.key_code !== 4'h5) begin errors++; $display("FAIL ovr_first got=%b/%h exp=1/5", kif.key_valid, kif.key_code); end
    press[1] = 4'h0;
    wait_col_not(4'b1101, 30, ok);
    wait_col_not(4'b1110, 30, ok);
    press[0] = 4'b1000;
    ok = 1'b0;
    for (int unsigned i = 0; i < VBUDGET; i++) begin
      @(negedge clock);
      if (kif.overrun === 1'b1) begin ok = 1'b1; break; end
    end
    exp_ovr = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL ovr_flag got=0 exp=1"); end
    checks++; if (kif.key_code !== 4'h5 || kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_keep got=%b/%h exp=1/5", kif.key_valid, kif.key_code);
    end
    press[0] = 4'h0;
    wait_col_not(4'b1110, 30, ok);
    pulse_ready();
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL ovr_transfer got=%b exp=0", kif.key_valid); end
    checks++; if (kif.overrun !== exp_ovr) begin errors++; $display("FAIL ovr_sticky got=%b exp=%b", kif.overrun, exp_ovr); end
  endtask

  task automatic test_reset_debounce();
    bit ok;
    int bad;
    wait_col_not(4'b1011, 20, ok);
    press[2] = 4'b0100;
    wait_col_is(4'b1011, 20, ok);
    repeat (6) @(negedge clock);
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rstdb_pre got=%b exp=0", kif.key_valid); end
    reset = 1'b0;
    #1;
    checks++; if (col !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_code !== 4'h0 || kif.overrun !== 1'b0) begin
      errors++; $display("FAIL rstdb_state got=%b/%b/%h/%b exp=1110/0/0/0", col, kif.key_valid, kif.key_code, kif.overrun);
    end
    exp_valid = 1'b0; exp_code = 4'h0; exp_ovr = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_valid(VBUDGET, ok);
    checks++; if (!ok || kif.key_code !== 4'h9) begin errors++; $display("FAIL rstdb_redetect got=%b/%h exp=1/9", kif.key_valid, kif.key_code); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (kif.key_valid !== 1'b1 || kif.overrun !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstdb_once got=%0d bad cycles exp=0", bad); end
    press[2] = 4'h0;
    wait_col_not(4'b1011, 30, ok);
    pulse_ready();
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rstdb_transfer got=%b exp=0", kif.key_valid); end
  endtask

  initial begin
    release_all();
    kif.key_ready = 1'b0;
    test_reset();
    test_scan();
    test_press_hold();
    test_bounce();
    test_two_rows();
    test_random_keys();
    test_overrun();
    test_reset_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad on a Pmod header so operands and op codes can be entered without the slide switches.
- Drives one column low at a time, samples the synchronized rows, debounces, and maps the press to a hex code.
- Presents each press to the register/ALU datapath through a one-entry valid/ready holding register.
- It is the input-side counterpart to the display scanner: that block drives anodes, this block reads keys.

Parameters:
- SCAN_DIV, 16'd50000: clock cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_CNT, 20'd500000: consecutive identical samples needed to accept a press or a release; must be >= 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clock.
- col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key_code  output  4  hex value of the accepted key.
- key_valid  output  1  key_code holds an untransferred key.
- key_ready  input  1  consumer accepts key_code on a clock edge where key_valid && key_ready.
- overrun  output  1  sticky flag: a key was accepted while the holding register was full.

Behaviour:
- Reset (reset low, asynchronous): state=SCAN, col=4'b1110, all counters 0, synchronizer flops 4'b1111, key_code=0, key_valid=0, overrun=0.
- Row input: two-flop synchronizer on row. rs is the second-stage value. Logic uses only rs.
- Key map (row r, col c, col0 leftmost):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Multiple rows low in one column: the lowest row index wins.
- FSM states: SCAN, DEBOUNCE, HELD.
- SCAN:
  - dwell counter counts 0..SCAN_DIV-1 with the current col driven.
  - On the cycle the counter equals SCAN_DIV-1, sample rs.
  - All rows high: advance col, rotating 0->1->2->3->0 (1110->1101->1011->0111->1110), and restart the dwell counter.
  - Any row low: latch the candidate row index and go to DEBOUNCE; col is not advanced.
- DEBOUNCE:
  - col is held.
  - Each cycle rs must show the candidate row low and rows of lower index high; the debounce counter then increments.
  - Any mismatch: return to SCAN, advance col, clear counters.
  - Counter reaches DEBOUNCE_CNT-1: accept the key and go to HELD.
- Accept, in the cycle after the counter reaches DEBOUNCE_CNT-1:
  - If key_valid=0: load key_code and set key_valid=1.
  - If key_valid=1 and not transferring that same cycle: drop the new key and set overrun=1.
  - Transfer and accept in the same cycle: the new key loads and key_valid stays 1.
- HELD:
  - col is held.
  - rs must read 4'b1111 for DEBOUNCE_CNT consecutive cycles; any low row restarts the count.
  - On completion: go to SCAN, advance col.
  - A held key produces exactly one acceptance, with no auto-repeat.
- Handshake:
  - key_valid falls on the edge where key_valid && key_ready, unless a new accept occurs that same cycle.
  - key_code is stable while key_valid=1.
  - key_ready while key_valid=0 has no effect.
- overrun: cleared only by reset.
- Latency: press contact to key_valid is at most 4*SCAN_DIV + DEBOUNCE_CNT + 3 cycles once row is stable.
- Reset asserted mid-debounce or mid-HELD: return to the reset state immediately with no key emitted. A key still held after reset is re-detected as a new press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
- After reset, row=1111: col cycles 1110,1101,1011,0111 every 4 cycles. key_valid=0, overrun=0.
- Press r1/c2 (row=1101 while col=1011), key_ready=0:
  - key_valid rises with key_code=4'h6.
  - col stays 1011 until release is debounced.
  - Then key_ready=1 for 1 cycle drops key_valid.
- Bounce: r0/c0 low for 3 cycles then high:
  - no key_valid.
  - scanning resumes at col=1101.
- Two rows low in col 3 (row=0110): key_code=4'hA (r0 wins).
- Press '5' (key_ready=0), release, then press '0':
  - key_code stays 5.
  - overrun=1.
  - After a transfer with key_ready=1, key_valid=0 and overrun stays 1.
- Assert reset during DEBOUNCE of '9':
  - outputs at reset values.
  - Key still held after release of reset: key_code=9 reported once.
